// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address field helpers for the
// 2-way set-associative read cache.
package cache_pkg;

    localparam int ADDR_W      = 19;
    localparam int INDEX_W     = 6;
    localparam int TAG_W       = ADDR_W - INDEX_W - 3;
    localparam int LINE_W      = 64;
    localparam int WORD_W      = 32;
    localparam int NUM_SETS    = 1 << INDEX_W;
    localparam int SRAM_ADDR_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:INDEX_W+3];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[INDEX_W+2:3];
    endfunction

    function automatic logic addr_word_sel(input logic [ADDR_W-1:0] a);
        return a[2];
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic sel);
        return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side and SRAM-side signals of the cache controller.
// Handshake: the CPU holds mem_r_en/mem_w_en (and address/wdata) stable until it
// sees ready=1; the SRAM controller completes a request with a one-cycle sram_ready.
interface cache_controller_if;
    import cache_pkg::*;

    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [31:0]            address;
    logic [WORD_W-1:0]      wdata;
    logic [WORD_W-1:0]      rdata;
    logic                   ready;
    logic                   sram_mem_read;
    logic                   sram_mem_write;
    logic [SRAM_ADDR_W-1:0] sram_address;
    logic [WORD_W-1:0]      sram_wdata;
    logic [LINE_W-1:0]      sram_rdata;
    logic                   sram_ready;

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_mem_read, sram_mem_write, sram_address, sram_wdata
    );

    modport master (
        output mem_r_en, mem_w_en, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_mem_read, sram_mem_write, sram_address, sram_wdata
    );

endinterface

// File: rtl/cache_set_array.sv
// Valid/tag/data storage for both ways plus one LRU bit per set.
// Reads are asynchronous by index; fill, invalidate and LRU update are clocked.
module cache_set_array
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_W-1:0]      index,
    output logic [1:0]              valid,
    output logic [1:0][TAG_W-1:0]   tag,
    output logic [1:0][LINE_W-1:0]  data,
    output logic                    lru,
    input  logic                    fill_en,
    input  logic                    fill_way,
    input  logic [TAG_W-1:0]        fill_tag,
    input  logic [LINE_W-1:0]       fill_data,
    input  logic                    inv_en,
    input  logic                    inv_way,
    input  logic                    lru_en,
    input  logic                    lru_val
);

    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] lru_q;
    logic [TAG_W-1:0]    tag_q  [2][NUM_SETS];
    logic [LINE_W-1:0]   data_q [2][NUM_SETS];

    // Only valid and LRU need clearing; stale tag/data are masked by valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (fill_en) valid_q[fill_way][index] <= 1'b1;
            if (inv_en)  valid_q[inv_way][index]  <= 1'b0;
            if (lru_en)  lru_q[index]             <= lru_val;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_way][index]  <= fill_tag;
            data_q[fill_way][index] <= fill_data;
        end
    end

    assign valid = {valid_q[1][index], valid_q[0][index]};
    assign tag   = {tag_q[1][index], tag_q[0][index]};
    assign data  = {data_q[1][index], data_q[0][index]};
    assign lru   = lru_q[index];

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way read cache in front of the SRAM
// controller: zero-latency read hits, line fill on read miss, one store per write.
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus,
    output state_t             dbg_state
);

    state_t                   state, next_state;
    logic [ADDR_W-1:0]        req_addr;
    logic [WORD_W-1:0]        req_wdata;
    logic [ADDR_W-1:0]        lookup_addr;

    logic [1:0]               way_valid;
    logic [1:0][TAG_W-1:0]    way_tag;
    logic [1:0][LINE_W-1:0]   way_data;
    logic                     set_lru;

    logic [1:0]               hit_way;
    logic                     hit;
    logic                     hit_idx;
    logic [LINE_W-1:0]        hit_data;
    logic                     victim;

    logic                     fill_en;
    logic                     inv_en;
    logic                     lru_en;
    logic                     lru_val;

    logic                     unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[31:ADDR_W], bus.address[1:0], req_addr[0]};

    // While a request is outstanding the latched address drives the lookup.
    assign lookup_addr = (state == IDLE) ? bus.address[ADDR_W-1:0] : req_addr;

    cache_set_array u_set_array (
        .clk       (clk),
        .rst       (rst),
        .index     (addr_index(lookup_addr)),
        .valid     (way_valid),
        .tag       (way_tag),
        .data      (way_data),
        .lru       (set_lru),
        .fill_en   (fill_en),
        .fill_way  (victim),
        .fill_tag  (addr_tag(lookup_addr)),
        .fill_data (bus.sram_rdata),
        .inv_en    (inv_en),
        .inv_way   (hit_idx),
        .lru_en    (lru_en),
        .lru_val   (lru_val)
    );

    assign hit_way[0] = way_valid[0] && (way_tag[0] == addr_tag(lookup_addr));
    assign hit_way[1] = way_valid[1] && (way_tag[1] == addr_tag(lookup_addr));
    assign hit        = |hit_way;
    assign hit_idx    = hit_way[1];
    assign hit_data   = hit_idx ? way_data[1] : way_data[0];
    assign victim     = set_lru;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Capture the request every idle cycle; the value taken on the leaving edge sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (state == IDLE) begin
            req_addr  <= bus.address[ADDR_W-1:0];
            req_wdata <= bus.wdata;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.mem_w_en)                next_state = WRITE;
                else if (bus.mem_r_en && !hit)   next_state = READ_MISS;
            end
            READ_MISS: if (bus.sram_ready) next_state = IDLE;
            WRITE:     if (bus.sram_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ready          = 1'b0;
        bus.rdata          = '0;
        bus.sram_mem_read  = 1'b0;
        bus.sram_mem_write = 1'b0;
        bus.sram_address   = '0;
        bus.sram_wdata     = '0;
        fill_en            = 1'b0;
        inv_en             = 1'b0;
        lru_en             = 1'b0;
        lru_val            = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_w_en) begin
                    bus.ready = 1'b0;
                end else if (bus.mem_r_en) begin
                    if (hit) begin
                        bus.ready = 1'b1;
                        bus.rdata = line_word(hit_data, addr_word_sel(lookup_addr));
                        lru_en    = 1'b1;
                        lru_val   = ~hit_idx;
                    end
                end else begin
                    bus.ready = 1'b1;
                end
            end
            READ_MISS: begin
                bus.sram_mem_read = 1'b1;
                bus.sram_address  = {req_addr[ADDR_W-1:3], 2'b00};
                if (bus.sram_ready) begin
                    fill_en   = 1'b1;
                    lru_en    = 1'b1;
                    lru_val   = ~victim;
                    bus.ready = 1'b1;
                    bus.rdata = line_word(bus.sram_rdata, addr_word_sel(req_addr));
                end
            end
            WRITE: begin
                bus.sram_mem_write = 1'b1;
                bus.sram_address   = req_addr[ADDR_W-1:1];
                bus.sram_wdata     = req_wdata;
                // Invalidate rather than update so the cache never holds stale data.
                inv_en             = hit;
                bus.ready          = bus.sram_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: the bench plays both CPU and SRAM
// controller, with expected values worked out by hand per scenario.
module tb_cache_controller;
    import cache_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_fail   = 0;

    cache_controller_if bus();

    cache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.address    = '0;
        bus.wdata      = '0;
        bus.sram_rdata = '0;
        bus.sram_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        bus_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // CPU read; if it misses, the SRAM side answers with 'line' after 'lat' extra cycles.
    task automatic cpu_read(input logic [31:0] addr, input logic [63:0] line, input int lat,
                            output logic missed, output logic [31:0] rd,
                            output logic [17:0] sa, output logic srd_first, output logic done);
        @(posedge clk); #1;
        bus.mem_r_en = 1'b1;
        bus.address  = addr;
        @(negedge clk);
        srd_first = bus.sram_mem_read;
        sa        = '0;
        if (bus.ready) begin
            missed = 1'b0;
            rd     = bus.rdata;
            done   = 1'b1;
            @(posedge clk); #1;
            bus.mem_r_en = 1'b0;
        end else begin
            missed = 1'b1;
            @(negedge clk);
            sa = bus.sram_address;
            repeat (lat) @(posedge clk);
            @(posedge clk); #1;
            bus.sram_ready = 1'b1;
            bus.sram_rdata = line;
            @(negedge clk);
            rd   = bus.rdata;
            done = bus.ready;
            @(posedge clk); #1;
            bus.sram_ready = 1'b0;
            bus.sram_rdata = '0;
            bus.mem_r_en   = 1'b0;
        end
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic also_read,
                             output logic first_ready, output logic srd, output logic swr,
                             output logic [17:0] sa, output logic [31:0] sw, output logic done);
        @(posedge clk); #1;
        bus.mem_w_en = 1'b1;
        bus.mem_r_en = also_read;
        bus.address  = addr;
        bus.wdata    = data;
        @(negedge clk);
        first_ready = bus.ready;
        @(negedge clk);
        srd = bus.sram_mem_read;
        swr = bus.sram_mem_write;
        sa  = bus.sram_address;
        sw  = bus.sram_wdata;
        @(posedge clk); #1;
        bus.sram_ready = 1'b1;
        @(negedge clk);
        done = bus.ready;
        @(posedge clk); #1;
        bus.sram_ready = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.mem_r_en   = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1'b1;
        #12;
        @(negedge clk);
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        n_checks++; if (bus.sram_mem_read !== 1'b0 || bus.sram_mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_sram_req: got rd=%b wr=%b want 0 0", bus.sram_mem_read, bus.sram_mem_write); end
        n_checks++; if (bus.sram_address !== 18'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h want 0", bus.sram_address); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic missed, srd, done; logic [31:0] rd; logic [17:0] sa;
        apply_reset();
        cpu_read(32'h40, 64'h1111_2222_3333_4444, 2, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1) begin n_fail++; $display("FAIL cold_missed: got %b want 1", missed); end
        n_checks++; if (sa !== 18'h00020) begin n_fail++; $display("FAIL cold_sram_addr: got %h want 00020", sa); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cold_ready: got %b want 1", done); end
        n_checks++; if (rd !== 32'h3333_4444) begin n_fail++; $display("FAIL cold_rdata: got %h want 33334444", rd); end
        @(negedge clk);
        n_checks++; if (bus.sram_mem_read !== 1'b0) begin n_fail++; $display("FAIL cold_read_drop: got %b want 0", bus.sram_mem_read); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL cold_state: got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_hit();
        logic missed, srd, done; logic [31:0] rd; logic [17:0] sa;
        apply_reset();
        cpu_read(32'h40, 64'hCAFE_0001_1234_5678, 0, missed, rd, sa, srd, done);
        n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL hit_fill_rdata: got %h want 12345678", rd); end
        cpu_read(32'h40, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || srd !== 1'b0) begin n_fail++; $display("FAIL hit_lo_latency: got missed=%b srd=%b want 0 0", missed, srd); end
        n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL hit_lo_rdata: got %h want 12345678", rd); end
        cpu_read(32'h44, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || srd !== 1'b0) begin n_fail++; $display("FAIL hit_hi_latency: got missed=%b srd=%b want 0 0", missed, srd); end
        n_checks++; if (rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL hit_hi_rdata: got %h want cafe0001", rd); end
    endtask

    task automatic test_lru_evict();
        logic missed, srd, done; logic [31:0] rd; logic [17:0] sa;
        apply_reset();
        cpu_read(32'h040, 64'hA0A0_A0A0_0000_0A00, 0, missed, rd, sa, srd, done);
        cpu_read(32'h240, 64'hB1B1_B1B1_0000_0B01, 1, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1) begin n_fail++; $display("FAIL lru_second_tag_missed: got %b want 1", missed); end
        cpu_read(32'h444, 64'hC2C2_C2C2_0000_0C02, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1 || sa !== 18'h00220) begin n_fail++; $display("FAIL lru_third_miss: got missed=%b sa=%h want 1 00220", missed, sa); end
        n_checks++; if (rd !== 32'hC2C2_C2C2) begin n_fail++; $display("FAIL lru_third_rdata: got %h want c2c2c2c2", rd); end
        cpu_read(32'h240, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || rd !== 32'h0000_0B01) begin n_fail++; $display("FAIL lru_tag1_hit: got missed=%b rd=%h want 0 00000b01", missed, rd); end
        cpu_read(32'h440, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || rd !== 32'h0000_0C02) begin n_fail++; $display("FAIL lru_tag2_hit: got missed=%b rd=%h want 0 00000c02", missed, rd); end
        cpu_read(32'h040, 64'hD3D3_D3D3_0000_0D03, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1 || rd !== 32'h0000_0D03) begin n_fail++; $display("FAIL lru_tag0_evicted: got missed=%b rd=%h want 1 00000d03", missed, rd); end
    endtask

    task automatic test_write_invalidate();
        logic missed, srd, swr, done, first_ready; logic [31:0] rd, sw; logic [17:0] sa;
        apply_reset();
        cpu_read(32'h40, 64'h0BAD_F00D_0000_0040, 0, missed, rd, sa, srd, done);
        cpu_write(32'h40, 32'hDEAD_BEEF, 1'b0, first_ready, srd, swr, sa, sw, done);
        n_checks++; if (first_ready !== 1'b0) begin n_fail++; $display("FAIL wr_first_ready: got %b want 0", first_ready); end
        n_checks++; if (swr !== 1'b1 || srd !== 1'b0) begin n_fail++; $display("FAIL wr_sram_req: got wr=%b rd=%b want 1 0", swr, srd); end
        n_checks++; if (sa !== 18'h00020) begin n_fail++; $display("FAIL wr_sram_addr: got %h want 00020", sa); end
        n_checks++; if (sw !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_sram_wdata: got %h want deadbeef", sw); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", done); end
        cpu_read(32'h40, 64'h0000_0000_DEAD_BEEF, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_invalidated: got missed=%b rd=%h want 1 deadbeef", missed, rd); end
    endtask

    task automatic test_write_priority();
        logic missed, srd, swr, done, first_ready; logic [31:0] rd, sw; logic [17:0] sa;
        apply_reset();
        cpu_write(32'h84, 32'h0123_4567, 1'b1, first_ready, srd, swr, sa, sw, done);
        n_checks++; if (first_ready !== 1'b0) begin n_fail++; $display("FAIL prio_first_ready: got %b want 0", first_ready); end
        n_checks++; if (srd !== 1'b0 || swr !== 1'b1) begin n_fail++; $display("FAIL prio_path: got rd=%b wr=%b want 0 1", srd, swr); end
        n_checks++; if (sa !== 18'h00042 || sw !== 32'h0123_4567) begin n_fail++; $display("FAIL prio_sram: got sa=%h sw=%h want 00042 01234567", sa, sw); end
        cpu_read(32'h84, 64'h7654_3210_0000_0000, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1 || rd !== 32'h7654_3210) begin n_fail++; $display("FAIL prio_no_allocate: got missed=%b rd=%h want 1 76543210", missed, rd); end
    endtask

    task automatic test_dropped_request();
        logic missed, srd, done; logic [31:0] rd; logic [17:0] sa;
        apply_reset();
        @(posedge clk); #1;
        bus.mem_r_en = 1'b1;
        bus.address  = 32'h1C4;
        @(posedge clk); #1;
        bus.mem_r_en = 1'b0;
        bus.address  = '0;
        @(negedge clk);
        n_checks++; if (bus.sram_mem_read !== 1'b1 || bus.sram_address !== 18'h000E0) begin n_fail++; $display("FAIL drop_still_reading: got rd=%b sa=%h want 1 000e0", bus.sram_mem_read, bus.sram_address); end
        @(posedge clk); #1;
        bus.sram_ready = 1'b1;
        bus.sram_rdata = 64'h9988_7766_5544_3322;
        @(posedge clk); #1;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = '0;
        @(negedge clk);
        n_checks++; if (bus.sram_mem_read !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL drop_complete: got rd=%b state=%0d want 0 IDLE", bus.sram_mem_read, dbg_state); end
        cpu_read(32'h1C4, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || rd !== 32'h9988_7766) begin n_fail++; $display("FAIL drop_fill_kept: got missed=%b rd=%h want 0 99887766", missed, rd); end
    endtask

    task automatic test_reset_mid_miss();
        logic missed, srd, done; logic [31:0] rd; logic [17:0] sa;
        apply_reset();
        cpu_read(32'h40, 64'h5555_6666_7777_8888, 0, missed, rd, sa, srd, done);
        cpu_read(32'h40, 64'h0, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b0 || rd !== 32'h7777_8888) begin n_fail++; $display("FAIL rstmiss_prehit: got missed=%b rd=%h want 0 77778888", missed, rd); end
        @(posedge clk); #1;
        bus.mem_r_en = 1'b1;
        bus.address  = 32'h100;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.sram_mem_read !== 1'b1) begin n_fail++; $display("FAIL rstmiss_in_miss: got %b want 1", bus.sram_mem_read); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.sram_mem_read !== 1'b0 || dbg_state !== IDLE || bus.sram_address !== 18'h0) begin n_fail++; $display("FAIL rstmiss_async: got rd=%b state=%0d sa=%h want 0 IDLE 0", bus.sram_mem_read, dbg_state, bus.sram_address); end
        @(posedge clk); #1;
        bus.mem_r_en = 1'b0;
        rst = 1'b0;
        cpu_read(32'h40, 64'h1234_0000_0000_4321, 0, missed, rd, sa, srd, done);
        n_checks++; if (missed !== 1'b1 || rd !== 32'h0000_4321) begin n_fail++; $display("FAIL rstmiss_cleared: got missed=%b rd=%h want 1 00004321", missed, rd); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_cold_miss();
        test_hit();
        test_lru_evict();
        test_write_invalidate();
        test_write_priority();
        test_dropped_request();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
